// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequencer for the 64-bit HiLo register in the EX stage.
// Runs multi-cycle mult/div/madd/msub, single-cycle mthi/mtlo, drives the
// HiLo write port and stalls the pipeline while an operation is in flight.
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ReadReq,
    input  logic [63:0] HiLoCur,
    output logic [63:0] HiLoWrData,
    output logic        HiLoWrEn,
    output logic        Busy,
    output logic        Stall,
    output logic        DivByZero
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    // MUL state is held for MUL_LAT-1 cycles; the counter counts down to 0.
    localparam logic [4:0] MUL_CNT_INIT = (MUL_LAT >= 2) ? 5'(MUL_LAT - 2) : 5'd0;
    localparam bit         MUL_DIRECT   = (MUL_LAT == 1);
    // 32 quotient bits, one per DIV cycle.
    localparam logic [4:0] DIV_CNT_INIT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [3:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] quo_reg;
    logic [31:0] rem_reg;
    logic [31:0] dvs_reg;
    logic        quo_neg_reg;
    logic        rem_neg_reg;
    logic        b_zero_reg;

    logic        in_mul;
    logic        in_div;
    logic        in_signed;
    logic        accept;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] product;

    logic [32:0] div_diff;
    logic        div_fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    // Decode the op presented in EX and form operand magnitudes for the divider.
    always_comb begin
        in_div    = (Op[3:1] == 3'b001);
        in_mul    = (Op <= OP_MSUBU) && !in_div;
        in_signed = ~Op[0];
        accept    = Start && (state_reg == ST_IDLE) && (in_mul || in_div);
        a_mag     = (in_signed && A[31]) ? (~A + 32'd1) : A;
        b_mag     = (in_signed && B[31]) ? (~B + 32'd1) : B;
    end

    // Product from the latched operands; low 64 bits of the product of the
    // 64-bit sign/zero-extended operands are the exact 32x32 result.
    always_comb begin
        mul_a_ext = {{32{~op_reg[0] & a_reg[31]}}, a_reg};
        mul_b_ext = {{32{~op_reg[0] & b_reg[31]}}, b_reg};
        product   = mul_a_ext * mul_b_ext;
    end

    // One restoring shift-subtract step on the magnitudes.
    always_comb begin
        div_diff  = {rem_reg, quo_reg[31]} - {1'b0, dvs_reg};
        div_fits  = ~div_diff[32];
        rem_next  = div_fits ? div_diff[31:0] : {rem_reg[30:0], quo_reg[31]};
        quo_next  = {quo_reg[30:0], div_fits};
        quo_fixed = quo_neg_reg ? (~quo_reg + 32'd1) : quo_reg;
        rem_fixed = rem_neg_reg ? (~rem_reg + 32'd1) : rem_reg;
    end

    // Sequencer: accept in IDLE, count through MUL or DIV, single WR cycle.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            quo_neg_reg <= 1'b0;
            rem_neg_reg <= 1'b0;
            b_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg      <= Op;
                        a_reg       <= A;
                        b_reg       <= B;
                        b_zero_reg  <= (B == 32'd0);
                        quo_neg_reg <= in_signed && (A[31] ^ B[31]);
                        rem_neg_reg <= in_signed && A[31];
                        rem_reg     <= '0;
                        dvs_reg     <= b_mag;
                        quo_reg     <= in_div ? a_mag : 32'd0;
                        if (in_div) begin
                            cnt_reg   <= DIV_CNT_INIT;
                            state_reg <= ST_DIV;
                        end else if (MUL_DIRECT) begin
                            cnt_reg   <= '0;
                            state_reg <= ST_WR;
                        end else begin
                            cnt_reg   <= MUL_CNT_INIT;
                            state_reg <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt_reg == 5'd0) begin
                        state_reg <= ST_WR;
                    end else begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                ST_DIV: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (cnt_reg == 5'd0) begin
                        state_reg <= ST_WR;
                    end else begin
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // HiLo write port, busy and stall; everything forced low while in reset.
    always_comb begin
        HiLoWrData = '0;
        HiLoWrEn   = 1'b0;
        Busy       = 1'b0;
        Stall      = 1'b0;
        DivByZero  = 1'b0;
        if (Rst) begin
            Busy  = (state_reg != ST_IDLE);
            Stall = Busy && (Start || ReadReq);
            case (state_reg)
                ST_IDLE: begin
                    if (Start && (Op == OP_MTHI)) begin
                        HiLoWrEn   = 1'b1;
                        HiLoWrData = {A, HiLoCur[31:0]};
                    end else if (Start && (Op == OP_MTLO)) begin
                        HiLoWrEn   = 1'b1;
                        HiLoWrData = {HiLoCur[63:32], A};
                    end
                end
                ST_WR: begin
                    case (op_reg)
                        OP_MULT, OP_MULTU: begin
                            HiLoWrEn   = 1'b1;
                            HiLoWrData = product;
                        end
                        OP_MADD, OP_MADDU: begin
                            HiLoWrEn   = 1'b1;
                            HiLoWrData = HiLoCur + product;
                        end
                        OP_MSUB, OP_MSUBU: begin
                            HiLoWrEn   = 1'b1;
                            HiLoWrData = HiLoCur - product;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_zero_reg) begin
                                DivByZero = 1'b1;
                            end else begin
                                HiLoWrEn   = 1'b1;
                                HiLoWrData = {rem_fixed, quo_fixed};
                            end
                        end
                        default: begin
                            HiLoWrEn = 1'b0;
                        end
                    endcase
                end
                default: begin
                    HiLoWrEn = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Testbench for hilo_muldiv_ctrl: directed cases plus randomized ops, with a
// scoreboard of expected HiLo writes / divide-by-zero pulses filled by the
// stimulus side and drained by an independent monitor.
module tb_hilo_muldiv_ctrl;

    localparam int MUL_LAT = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        ReadReq = 1'b0;
    logic [63:0] HiLoCur;
    logic [63:0] HiLoWrData;
    logic        HiLoWrEn;
    logic        Busy;
    logic        Stall;
    logic        DivByZero;

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Op         (Op),
        .A          (A),
        .B          (B),
        .ReadReq    (ReadReq),
        .HiLoCur    (HiLoCur),
        .HiLoWrData (HiLoWrData),
        .HiLoWrEn   (HiLoWrEn),
        .Busy       (Busy),
        .Stall      (Stall),
        .DivByZero  (DivByZero)
    );

    always #5 Clk = ~Clk;

    // The HiLo register itself lives in the bench.
    logic [63:0] hilo_q = 64'd0;
    assign HiLoCur = hilo_q;
    always @(posedge Clk) if (HiLoWrEn) hilo_q <= HiLoWrData;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          when;
        logic [63:0] data;
        logic        dbz;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] model_hilo = 64'd0;
    int          busy_from = -1;
    int          busy_to = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Reference model: what the op must do to HiLo, and when.
    task automatic model_accept(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int c);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        int              ia, ib, iq, ir;
        logic [31:0]     q, r;
        exp_t            e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = op[0] ? ua * ub : longint'(sa * sb);
        e.dbz = 1'b0;
        if (op <= 4'd7 && op != 4'd2 && op != 4'd3) begin
            if (op <= 4'd1)      e.data = p;
            else if (op <= 4'd5) e.data = model_hilo + p;
            else                 e.data = model_hilo - p;
            e.when = c + MUL_LAT;
            model_hilo = e.data;
            busy_from = c;
            busy_to = c + MUL_LAT;
            exp_q.push_back(e);
        end else if (op == 4'd2 || op == 4'd3) begin
            e.when = c + 33;
            busy_from = c;
            busy_to = c + 33;
            if (b == 32'd0) begin
                e.dbz = 1'b1;
                e.data = 64'd0;
            end else begin
                if (op == 4'd3) begin
                    q = a / b;
                    r = a % b;
                end else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    if (a == 32'h8000_0000 && ib == -1) begin
                        q = 32'h8000_0000;
                        r = 32'd0;
                    end else begin
                        iq = ia / ib;
                        ir = ia % ib;
                        q = iq;
                        r = ir;
                    end
                end
                e.data = {r, q};
                model_hilo = e.data;
            end
            exp_q.push_back(e);
        end else if (op == 4'd8 || op == 4'd9) begin
            e.when = c;
            e.data = (op == 4'd8) ? {a, model_hilo[31:0]} : {model_hilo[63:32], a};
            model_hilo = e.data;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present an op until the DUT stops stalling it; returns acceptance cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int acc);
        int n;
        n = 0;
        acc = -1;
        ReadReq = 1'b0;
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        while (acc < 0 && n < 200) begin
            #1;
            if (!Stall) begin
                acc = cyc;
                model_accept(op, a, b, cyc);
            end
            tick();
            n++;
        end
        Start = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout op=%0d actual=stalled required=accepted", op);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        tick();
    endtask

    // Monitor: compares every cycle against the scoreboard and busy model.
    always @(negedge Clk) begin : monitor
        exp_t e;
        bit   busy_e;
        if (!Rst) begin
            chk("rst_wren", HiLoWrEn, 0);
            chk("rst_data", HiLoWrData, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_stall", Stall, 0);
            chk("rst_dbz", DivByZero, 0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event due=%0d actual=none required=%h", e.when, e.data);
            end
            if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
                e = exp_q.pop_front();
                chk("wr_en", HiLoWrEn, e.dbz ? 0 : 1);
                chk("div_by_zero", DivByZero, e.dbz);
                if (!e.dbz) chk("wr_data", HiLoWrData, e.data);
            end else begin
                chk("spurious_event", {HiLoWrEn, DivByZero}, 0);
            end
            if (!HiLoWrEn) chk("data_zero", HiLoWrData, 0);
            busy_e = (cyc > busy_from) && (cyc <= busy_to);
            chk("busy", Busy, busy_e);
            chk("stall", Stall, busy_e && (Start || ReadReq));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          acc, acc2, k;
        logic [63:0] saved;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) tick();
        Rst = 1'b1;
        tick();

        // MULT / MULTU of -2 and 3
        issue(4'd0, 32'hFFFF_FFFE, 32'd3, acc);
        wait_idle();
        chk("mult_result", hilo_q, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, acc);
        wait_idle();
        chk("multu_result", hilo_q, 64'h0000_0002_FFFF_FFFA);

        // DIV -7/2, DIVU by zero, overflow divide
        issue(4'd2, 32'hFFFF_FFF9, 32'd2, acc);
        wait_idle();
        chk("div_result", hilo_q, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(4'd3, 32'd7, 32'd0, acc);
        wait_idle();
        chk("divu_zero_unchanged", hilo_q, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, acc);
        wait_idle();
        chk("div_overflow", hilo_q, 64'h0000_0000_8000_0000);

        // MADDU then MSUB from HiLo = 0x00000000_FFFFFFFF
        issue(4'd8, 32'd0, 32'd0, acc);
        issue(4'd9, 32'hFFFF_FFFF, 32'd0, acc);
        issue(4'd5, 32'd1, 32'd1, acc);
        wait_idle();
        chk("maddu_result", hilo_q, 64'h0000_0001_0000_0000);
        issue(4'd6, 32'd1, 32'd2, acc);
        wait_idle();
        chk("msub_result", hilo_q, 64'h0000_0000_FFFF_FFFE);

        // Back-to-back MTLO / MTHI
        issue(4'd9, 32'h1234_5678, 32'd0, acc);
        issue(4'd8, 32'hCAFE_BABE, 32'd0, acc2);
        chk("mt_back_to_back", acc2 - acc, 1);
        wait_idle();
        chk("mt_result", hilo_q, 64'hCAFE_BABE_1234_5678);

        // ReadReq through a DIV, then MULT presented in its WR cycle
        issue(4'd2, 32'd100, 32'd7, acc);
        ReadReq = 1'b1;
        repeat (32) tick();
        ReadReq = 1'b0;
        issue(4'd0, 32'd5, 32'd6, acc2);
        chk("wr_cycle_accept", acc2 - acc, 34);
        wait_idle();
        chk("mult_after_div", hilo_q, 64'd30);

        // Reset in the middle of a DIV aborts it
        saved = model_hilo;
        issue(4'd2, 32'd1000, 32'd3, acc);
        repeat (10) tick();
        exp_q.delete();
        busy_to = -1;
        model_hilo = saved;
        Rst = 1'b0;
        repeat (2) tick();
        Rst = 1'b1;
        repeat (40) tick();
        chk("reset_abort_hilo", hilo_q, saved);

        // Randomized ops, gaps and reads
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = $urandom();
            k = $urandom_range(0, 7);
            if (k == 0) rb = 32'd0;
            if (k == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (k == 2) rb = 32'($urandom_range(1, 9));
            issue(rop, ra, rb, acc);
            k = $urandom_range(0, 3);
            for (int g = 0; g < k; g++) begin
                ReadReq = 1'($urandom_range(0, 1));
                tick();
            end
            ReadReq = 1'b0;
        end
        wait_idle();
        chk("final_hilo", hilo_q, model_hilo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
